seq_out_buffer: RTL

Double-buffered result store sitting directly downstream of the DSP sequencer. Captures the sequencer's output-port writes (`out_we`/`out_addr`/`out_audio`) into the write bank during a sequence run. When the sequencer raises `done`, the banks swap and the completed frame is streamed out, one channel per handshake, to the serialiser stage. Detects and counts frames lost because the consumer was too slow.

---
 rtl/seq_out_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_out_buffer.sv
// Double-buffered capture of sequencer output writes, streamed out one channel per handshake.
// Counts frames dropped when a new frame finishes before the previous one has drained.
module seq_out_buffer #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              out_we,
   input  logic [ADDR_W-1:0] out_addr,
   input  logic [15:0]       out_audio,
   input  logic              done,
   output logic [15:0]       tx_data,
   output logic [3:0]        tx_chan,
   output logic              tx_valid,
   output logic              tx_last,
   input  logic              tx_ready,
   output logic              overrun,
   output logic [7:0]        overrun_count
);

   typedef enum logic [0:0] {StIdle, StSend} state_t;

   state_t              state_q, state_d;
   logic [15:0]         mem [2][CHANNELS];
   logic [CHANNELS-1:0] mask_q [2];
   logic                wbank_q;
   logic                rbank;
   logic                done_q;
   logic [3:0]          rd_chan_q;
   logic                overrun_q;
   logic [7:0]          ovr_cnt_q;
   logic                rise, swap, xfer, last;
   logic [15:0]         rd_word;
   logic                rd_mask;

   assign rbank = ~wbank_q;
   assign rise  = done & ~done_q;
   assign swap  = rise & (state_q == StIdle);
   assign xfer  = (state_q == StSend) & tx_ready;
   assign last  = (rd_chan_q == 4'(CHANNELS - 1));

   // Sample storage needs no reset: the masks hide stale contents.
   always_ff @(negedge ck) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (out_we && 32'(out_addr) == 32'(c)) mem[wbank_q][c] <= out_audio;
      end
   end

   always_ff @(negedge ck or negedge rst) begin
      if (!rst) begin
         mask_q[0] <= '0;
         mask_q[1] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (out_we && 32'(out_addr) == 32'(c)) mask_q[wbank_q][c] <= 1'b1;
         end
         // A write on the swapping edge lands in the old bank, so it never collides with this clear.
         if (swap) mask_q[rbank] <= '0;
      end
   end

   always_ff @(negedge ck or negedge rst) begin
      if (!rst) begin
         done_q    <= 1'b0;
         wbank_q   <= 1'b0;
         rd_chan_q <= '0;
         overrun_q <= 1'b0;
         ovr_cnt_q <= '0;
      end else begin
         done_q <= done;
         if (swap) begin
            wbank_q   <= ~wbank_q;
            rd_chan_q <= '0;
         end else if (xfer) begin
            rd_chan_q <= rd_chan_q + 4'd1;
         end
         if (rise && state_q == StSend) begin
            overrun_q <= 1'b1;
            if (ovr_cnt_q != 8'hff) ovr_cnt_q <= ovr_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(negedge ck or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (rise) state_d = StSend;
         StSend: if (xfer && last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_word = '0;
      rd_mask = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_chan_q == 4'(c)) begin
            rd_word = mem[rbank][c];
            rd_mask = mask_q[rbank][c];
         end
      end
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_chan  = '0;
      tx_last  = 1'b0;
      if (state_q == StSend) begin
         tx_valid = 1'b1;
         tx_data  = rd_mask ? rd_word : 16'h0000;
         tx_chan  = rd_chan_q;
         tx_last  = last;
      end
   end

   assign overrun       = overrun_q;
   assign overrun_count = ovr_cnt_q;

endmodule
